// File: rtl/psg_bus_responder_if.sv
// CPU-side sound bus as seen by the PSG register file.
// The bus carries the BDIR/BC1 mode pair, write data, read-back data and the
// read drive enable. The CPU port logic uses the master side and
// psg_bus_responder uses the slave side.
interface psg_bus_responder_if;
  logic       bdir;
  logic       bc;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       data_oe;

  modport master (
    output bdir,
    output bc,
    output data_i,
    input  data_o,
    input  data_oe
  );

  modport slave (
    input  bdir,
    input  bc,
    input  data_i,
    output data_o,
    output data_oe
  );
endinterface

// File: rtl/psg_bus_responder.sv
// PSG-side bus responder for the FM-7 sound path (CLKSYS domain).
// It decodes the BDIR/BC1 modes (00 IDLE, 01 READ, 10 WRITE, 11 LATCH) and
// owns the 16-entry AY-3-8910/YM2149 register file. The registers feed the
// tone, noise and envelope generators directly.
// Optional build macro PSG_CHIPSEL_EN: the chip answers only while
// addr_q[7:4] == CHIP_ADDR. Without it the upper address nibble is ignored.
module psg_bus_responder #(
  parameter logic [3:0] CHIP_ADDR = 4'h0,
  parameter logic [7:0] READ_IDLE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  psg_bus_responder_if.slave bus,
  output logic [11:0]       tone_a,
  output logic [11:0]       tone_b,
  output logic [11:0]       tone_c,
  output logic [4:0]        noise_period,
  output logic [7:0]        mixer,
  output logic [4:0]        amp_a,
  output logic [4:0]        amp_b,
  output logic [4:0]        amp_c,
  output logic [15:0]       env_period,
  output logic [3:0]        env_shape,
  output logic              env_restart,
  output logic [7:0]        ioa_out,
  output logic [7:0]        iob_out,
  input  logic [7:0]        ioa_in,
  input  logic [7:0]        iob_in
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READ  = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;
  localparam logic [1:0] ST_LATCH = 2'b11;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] din_q;
  logic [7:0] addr_q;
  logic [7:0] addr_d;
  logic [7:0] wdata_q;
  logic [7:0] wdata_d;
  logic [7:0] regs_q [16];
  logic       sel;
  logic       commit;
  logic [3:0] idx;
  logic [7:0] rd_mux;
  logic [7:0] data_o_q;
  logic [7:0] data_o_d;
  logic       data_oe_q;
  logic       data_oe_d;
  logic       env_restart_q;
  logic       env_restart_d;

  // Storage keeps all 8 bits. Unused upper bits read back as zero.
  function automatic logic [7:0] read_mask(input logic [3:0] ridx, input logic [7:0] val);
    case (ridx)
      4'd1, 4'd3, 4'd5, 4'd13: return {4'h0, val[3:0]};
      4'd6, 4'd8, 4'd9, 4'd10: return {3'b000, val[4:0]};
      default:                 return val;
    endcase
  endfunction

  // The incoming mode pair is the next FSM state.
  assign state_d = {bus.bdir, bus.bc};
  assign idx     = addr_q[3:0];

`ifdef PSG_CHIPSEL_EN
  assign sel = (addr_q[7:4] == CHIP_ADDR);
`else
  logic unused_sel_bits;
  assign sel             = 1'b1;
  assign unused_sel_bits = ^{addr_q[7:4], CHIP_ADDR};
`endif

  // Register the bus inputs once. The registered mode is the FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      din_q   <= bus.data_i;
    end
  end

  // LATCH cycles load the address and WRITE cycles load the write data.
  // In both cases the last cycle of a run wins.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == ST_LATCH) addr_d = din_q;
    if (state_q == ST_WRITE) wdata_d = din_q;
  end

  // A WRITE run commits once, on the clock where the state leaves WRITE.
  // The commit uses the address held before any following LATCH takes effect.
  assign commit = (state_q == ST_WRITE) && (state_d != ST_WRITE) && sel;

  // Hold the address and write-data latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Update the register file when a committed write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else if (commit) begin
      regs_q[idx] <= wdata_d;
    end
  end

  // Read mux. Each I/O port reads its pins while the mixer marks it as an input.
  always_comb begin
    rd_mux = read_mask(idx, regs_q[idx]);
    if (idx == 4'd14) rd_mux = regs_q[7][6] ? regs_q[14] : ioa_in;
    if (idx == 4'd15) rd_mux = regs_q[7][7] ? regs_q[15] : iob_in;
  end

  always_comb begin
    data_oe_d     = (state_q == ST_READ) && sel;
    data_o_d      = data_oe_d ? rd_mux : READ_IDLE;
    env_restart_d = commit && (idx == 4'd13);
  end

  // Register the read-back, drive enable and envelope restart strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o_q      <= READ_IDLE;
      data_oe_q     <= 1'b0;
      env_restart_q <= 1'b0;
    end else begin
      data_o_q      <= data_o_d;
      data_oe_q     <= data_oe_d;
      env_restart_q <= env_restart_d;
    end
  end

  assign bus.data_o   = data_o_q;
  assign bus.data_oe  = data_oe_q;
  assign env_restart  = env_restart_q;

  assign tone_a       = {regs_q[1][3:0], regs_q[0]};
  assign tone_b       = {regs_q[3][3:0], regs_q[2]};
  assign tone_c       = {regs_q[5][3:0], regs_q[4]};
  assign noise_period = regs_q[6][4:0];
  assign mixer        = regs_q[7];
  assign amp_a        = regs_q[8][4:0];
  assign amp_b        = regs_q[9][4:0];
  assign amp_c        = regs_q[10][4:0];
  assign env_period   = {regs_q[12], regs_q[11]};
  assign env_shape    = regs_q[13][3:0];
  assign ioa_out      = regs_q[14];
  assign iob_out      = regs_q[15];

endmodule

// File: doc/psg_bus_responder.md
Name: psg_bus_responder

Overview:
- PSG-side bus responder for the FM-7 sound path: decodes the BDIR/BC1 bus modes driven by the CPU-side sound control port and owns the AY-3-8910/YM2149 16-entry register file.
- Implements address latch, register writes, masked read-back, I/O port muxing and a one-cycle envelope-restart strobe.
- Outputs feed the tone/noise/envelope generators directly; sits between the CPU port logic and the PSG synthesis core, all in the CLKSYS domain.

Parameters:
- CHIP_ADDR, 4'h0, upper address nibble the chip answers to; used only with PSG_CHIPSEL_EN.
- READ_IDLE, 8'hFF, value driven on data_o when the chip is not selected or the bus is not in READ.

Ports:
- clk  input  1  system clock (CLKSYS)
- reset  input  1  reset, asynchronous, active-high
- bdir  input  1  bus direction, synchronous to clk
- bc  input  1  bus control (BC1), synchronous to clk
- data_i  input  8  CPU data bus
- data_o  output  8  read-back data
- data_oe  output  1  read data valid / drive enable
- tone_a, tone_b, tone_c  output  12 each  tone periods {R1[3:0],R0}, {R3[3:0],R2}, {R5[3:0],R4}
- noise_period  output  5  R6[4:0]
- mixer  output  8  R7
- amp_a, amp_b, amp_c  output  5 each  R8/R9/R10[4:0]
- env_period  output  16  {R12,R11}
- env_shape  output  4  R13[3:0]
- env_restart  output  1  one-clk pulse on every R13 write
- ioa_out, iob_out  output  8 each  R14/R15 latches
- ioa_in, iob_in  input  8 each  external port pins

Behaviour:
- Bus mode decode of {bdir,bc}: 00 IDLE, 01 READ, 10 WRITE, 11 LATCH. Inputs are registered once; FSM state = registered mode.
- LATCH: each clk in LATCH loads addr_q <= data_i. Last value wins; addr_q is 8 bits, register index = addr_q[3:0].
- WRITE: each clk in WRITE captures wdata_q <= data_i. Commit happens on the clk where the state leaves WRITE (to any mode); the value committed is from the last WRITE cycle. WRITE->LATCH commits to the old address, then latches the new one. Back-to-back WRITE cycles commit exactly once.
- Commit stores the full 8 bits into R[addr]. Masking is applied on the outputs and read-back, not on storage.
- Commit to index 13 asserts env_restart for exactly one clk, including when the value is rewritten unchanged.
- READ:
  - data_oe = 1 and data_o = masked R[addr], one clk after the mode enters READ; both remain valid while in READ.
  - Masks: R1/R3/R5/R13 upper 4 bits = 0; R6/R8/R9/R10 upper 3 bits = 0.
  - R14 returns ioa_in when mixer[6]=0, otherwise ioa_out. R15 returns iob_in when mixer[7]=0, otherwise iob_out.
  - Outside READ: data_oe = 0 and data_o = READ_IDLE.
  - LATCH/WRITE->READ: read reflects the committed value in the first READ data cycle (commit precedes the read mux).
- Reset, asynchronous: all 16 registers = 0, addr_q = 0, wdata_q = 0, state IDLE, data_oe = 0, data_o = READ_IDLE, env_restart = 0.
- Reset asserted mid-WRITE: no commit occurs.
- Illegal or simultaneous events do not exist beyond the 4 modes. Mode changes every clk are legal.

Optional Feature:
- PSG_CHIPSEL_EN defined:
  - Chip is selected only when addr_q[7:4] == CHIP_ADDR.
  - Unselected: commits are discarded (no env_restart), and READ gives data_oe = 0, data_o = READ_IDLE.
  - LATCH always loads addr_q, so reselection is possible.
- Undefined: addr_q[7:4] is ignored and the chip is always selected.

Test Plan:
- Reset then READ R7 -> data_oe = 1 one clk after entry, data_o = 8'h00. Outside READ, data_o = 8'hFF.
- LATCH 8'h01, WRITE 8'hAB, IDLE, then READ -> data_o = 8'h0B; tone_a = 12'hB00. Write R0 = 8'h34 -> tone_a = 12'hB34.
- LATCH 13, WRITE 8'h0E for 3 clks, IDLE -> single env_restart pulse, env_shape = 4'hE. Repeat the same write -> second pulse.
- mixer = 8'h00, ioa_in = 8'h5A, READ R14 -> 8'h5A. Set mixer = 8'h40 and ioa_out = 8'hC3 -> READ R14 = 8'hC3.
- LATCH 8, WRITE 8'h3F, then assert reset during WRITE -> amp_a stays 5'h00. A second sequence with no reset -> amp_a = 5'h1F and read-back = 8'h1F.
- With PSG_CHIPSEL_EN and CHIP_ADDR = 4'h1: LATCH 8'h02, WRITE 8'h55 -> R2 unchanged and READ gives data_oe = 0. LATCH 8'h12, WRITE 8'h55 -> tone_b[7:0] = 8'h55.
